// File: rtl/tdm_demux_sched.sv
// Round-robin TDM scheduler for the 1x8 demux path: steers each accepted serial bit
// to the next enabled channel, holds a per-channel data bank and counts completed frames.
module tdm_demux_sched #(
  parameter int NCH  = 8,
  parameter int SELW = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NCH-1:0]  ch_mask,
  input  logic            I,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [SELW-1:0] s,
  output logic [NCH-1:0]  y,
  output logic [NCH-1:0]  y_valid,
  output logic            frame_done,
  output logic [CNTW-1:0] frame_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] s_q, s_d;
  logic [NCH-1:0]  y_q, y_d;
  logic [NCH-1:0]  y_valid_q, y_valid_d;
  logic            frame_done_q, frame_done_d;
  logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic            last_ch_s;

  function automatic logic [SELW-1:0] lowest_bit(input logic [NCH-1:0] m);
    logic [SELW-1:0] r;
    r = {SELW{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) r = i[SELW-1:0];
    end
    return r;
  endfunction

  // Lowest set bit strictly above cur; gaps in the mask collapse to one step.
  function automatic logic [SELW-1:0] next_bit(input logic [NCH-1:0] m, input logic [SELW-1:0] cur);
    logic [SELW-1:0] r;
    r = cur;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = i[SELW-1:0];
    end
    return r;
  endfunction

  assign last_ch_s = ((mask_q >> s_q) == {{(NCH-1){1'b0}}, 1'b1});

  // Next-state computation for the scheduler and its output registers.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    y_d          = y_q;
    y_valid_d    = {NCH{1'b0}};
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    mask_d       = mask_q;
    case (state_q)
      IDLE: begin
        if (en && (ch_mask != {NCH{1'b0}})) begin
          state_d = RUN;
          mask_d  = ch_mask;
          s_d     = lowest_bit(ch_mask);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (in_valid) begin
          y_d[s_q]  = I;
          y_valid_d = {{(NCH-1){1'b0}}, 1'b1} << s_q;
          if (last_ch_s) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            if (en && (ch_mask != {NCH{1'b0}})) begin
              mask_d = ch_mask;
              s_d    = lowest_bit(ch_mask);
            end else begin
              state_d = IDLE;
              s_d     = {SELW{1'b0}};
            end
          end else begin
            s_d = next_bit(mask_q, s_q);
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = {SELW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= {SELW{1'b0}};
      y_q          <= {NCH{1'b0}};
      y_valid_q    <= {NCH{1'b0}};
      frame_done_q <= 1'b0;
      frame_cnt_q  <= {CNTW{1'b0}};
      mask_q       <= {NCH{1'b0}};
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      mask_q       <= mask_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign s          = s_q;
  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux_sched.sv
// Randomized and directed bench for tdm_demux_sched against a channel-list reference model.
module tb_tdm_demux_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       din = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] s;
  logic [7:0] y;
  logic [7:0] y_valid;
  logic       frame_done;
  logic [7:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  // Reference model: the frame is a list of enabled channel numbers walked by index.
  int   chans[$];
  bit   m_run = 1'b0;
  int   m_idx = 0;
  logic [7:0] m_y = 8'h00;
  logic [7:0] m_yv = 8'h00;
  logic m_fd = 1'b0;
  int   m_cnt = 0;

  tdm_demux_sched dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .I(din),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .y(y),
    .y_valid(y_valid), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void load_frame(input logic [7:0] m);
    chans.delete();
    for (int k = 0; k < 8; k++) begin
      if (m[k]) chans.push_back(k);
    end
    m_idx = 0;
  endfunction

  function automatic logic [2:0] model_sel();
    int c;
    c = m_run ? chans[m_idx] : 0;
    return 3'(c);
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_idx = 0; m_y = 8'h00; m_yv = 8'h00; m_fd = 1'b0; m_cnt = 0;
      chans.delete();
    end else begin
      m_yv = 8'h00;
      m_fd = 1'b0;
      if (!m_run) begin
        if (en && ch_mask != 8'h00) begin
          load_frame(ch_mask);
          m_run = 1'b1;
        end
      end else if (in_valid) begin
        m_y[chans[m_idx]] = din;
        m_yv = 8'h01 << chans[m_idx];
        m_idx++;
        if (m_idx == chans.size()) begin
          m_fd = 1'b1;
          m_cnt = (m_cnt + 1) % 256;
          if (en && ch_mask != 8'h00) load_frame(ch_mask);
          else m_run = 1'b0;
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready",   32'(in_ready),   32'(m_run));
      chk("s",          32'(s),          32'(model_sel()));
      chk("y",          32'(y),          32'(m_y));
      chk("y_valid",    32'(y_valid),    32'(m_yv));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b0100_1101;

    // Reset with valid and enable asserted.
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; ch_mask = 8'hFF; din = 1'b1;
    step();
    checking = 1'b1;
    step();
    chk("rst_y", 32'(y), 32'h00);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);

    // Full frame.
    rst = 1'b0;
    step();
    chk("full_s0", 32'(s), 32'h0);
    for (int k = 0; k < 8; k++) begin
      din = pat[k];
      step();
      chk("full_yv", 32'(y_valid), 32'h1 << k);
    end
    chk("full_y", 32'(y), 32'h4D);
    chk("full_fd", 32'(frame_done), 32'h1);
    chk("full_cnt", 32'(frame_cnt), 32'h1);
    chk("full_wrap_s", 32'(s), 32'h0);
    chk("full_ready", 32'(in_ready), 32'h1);

    // Sparse mask.
    do_reset();
    ch_mask = 8'hA4; din = 1'b1; in_valid = 1'b1;
    step();
    chk("sparse_s2", 32'(s), 32'h2);
    step();
    chk("sparse_s5", 32'(s), 32'h5);
    step();
    chk("sparse_s7", 32'(s), 32'h7);
    chk("sparse_fd0", 32'(frame_done), 32'h0);
    step();
    chk("sparse_y", 32'(y), 32'hA4);
    chk("sparse_fd", 32'(frame_done), 32'h1);
    chk("sparse_sw", 32'(s), 32'h2);

    // Stall.
    do_reset();
    ch_mask = 8'hFF; in_valid = 1'b1; din = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("stall_s_a", 32'(s), 32'h1);
    step();
    chk("stall_s_b", 32'(s), 32'h1);
    chk("stall_yv", 32'(y_valid), 32'h00);
    in_valid = 1'b1;
    step();
    chk("stall_ch1", 32'(y_valid), 32'h02);

    // Mid-frame mask/enable change.
    do_reset();
    ch_mask = 8'hFF; en = 1'b1; in_valid = 1'b1; din = 1'b0;
    step();
    for (int k = 0; k < 3; k++) step();
    ch_mask = 8'h03; en = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_yv", 32'(y_valid), 32'h80);
    chk("mid_fd", 32'(frame_done), 32'h1);
    chk("mid_ready", 32'(in_ready), 32'h0);
    chk("mid_s", 32'(s), 32'h0);

    // Reset during channel 4.
    ch_mask = 8'hFF; en = 1'b1; din = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("rmid_s4", 32'(s), 32'h4);
    do_reset();
    chk("rmid_fd", 32'(frame_done), 32'h0);
    chk("rmid_y", 32'(y), 32'h00);
    chk("rmid_s", 32'(s), 32'h0);

    // Counter wrap with single-channel frames.
    ch_mask = 8'h01; en = 1'b1; in_valid = 1'b1;
    step();
    for (int k = 0; k < 256; k++) begin
      din = 1'($urandom_range(0, 1));
      step();
    end
    chk("wrap_cnt", 32'(frame_cnt), 32'h0);
    chk("wrap_fd", 32'(frame_done), 32'h1);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      ch_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      din = 1'($urandom_range(0, 1));
      step();
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
